// File: rtl/nmcu_sim_main_mem.sv
// nmcu_sim_main_mem
//   Behavioural main-memory model sitting behind the NMCU memory-request path.
//   Accepts one request at a time. Reads return a burst of len words (len==0
//   treated as 1), one beat per cycle with resp_ready_i back-pressure. Writes
//   commit at the accept edge and return a single ack beat. The first response
//   beat is presented LATENCY cycles after the accept edge.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (storage array is not cleared)
//   req_i        : {valid, write_en, addr[31:0], wdata[31:0], len[7:0]}
//   req_ready_o  : high while idle, request may be accepted
//   resp_o       : {valid, addr[31:0], rdata[31:0], hit}
//   resp_ready_i : consumer accepts the current beat
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new request
// WAIT   | latency countdown, cnt_q reaching 0 moves to BURST
// BURST  | presenting beats, rem_q counts beats left after the current one
module nmcu_sim_main_mem #(
   parameter int unsigned LATENCY     = 5,
   parameter int unsigned DEPTH_WORDS = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [73:0] req_i,
   output logic        req_ready_o,
   output logic [65:0] resp_o,
   input  logic        resp_ready_i
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2
   } state_t;

   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  req_len;

   assign req_valid = req_i[73];
   assign req_we    = req_i[72];
   assign req_addr  = req_i[71:40];
   assign req_wdata = req_i[39:8];
   assign req_len   = req_i[7:0];

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    rem_q, rem_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          accept;

   logic [31:0]   mem_q [DEPTH_WORDS];

   assign accept = (state_q == S_IDLE) && req_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Writes commit at the accept edge so any later burst observes them.
   always_ff @(posedge clk) begin
      if (accept && req_we) begin
         mem_q[req_addr[AW+1:2]] <= req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_WAIT;
               cnt_d   = CW'(LATENCY - 1);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               // Writes always produce exactly one ack beat.
               rem_d   = (req_we || req_len == 8'd0) ? 8'd0 : req_len - 8'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_BURST;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_BURST: begin
            if (resp_ready_i) begin
               if (rem_q == 8'd0) begin
                  state_d = S_IDLE;
               end else begin
                  rem_d  = rem_q - 8'd1;
                  addr_d = addr_q + 32'd4;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic        resp_valid;
   logic [31:0] resp_rdata;

   assign req_ready_o = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_BURST);
   assign resp_rdata  = we_q ? wdata_q : mem_q[addr_q[AW+1:2]];

   assign resp_o = resp_valid ? {1'b1, addr_q, resp_rdata, 1'b1} : 66'd0;

endmodule

// File: tb/tb_nmcu_sim_main_mem.sv
module tb_nmcu_sim_main_mem;

   localparam int LAT   = 5;
   localparam int DEPTH = 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [73:0] req;
   logic        req_ready_o;
   logic [65:0] resp_o;
   logic        resp_ready = 1'b1;

   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [31:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic [7:0]  req_len   = '0;

   assign req = {req_valid, req_we, req_addr, req_wdata, req_len};

   nmcu_sim_main_mem #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .req_ready_o (req_ready_o),
      .resp_o      (resp_o),
      .resp_ready_i(resp_ready)
   );

   always #5 clk = ~clk;

   logic        r_valid, r_hit;
   logic [31:0] r_addr, r_rdata;
   assign r_valid = resp_o[65];
   assign r_addr  = resp_o[64:33];
   assign r_rdata = resp_o[32:1];
   assign r_hit   = resp_o[0];

   int n_assert = 0;
   int n_fail   = 0;

   // Reference memory: word index -> data, only for locations written so far.
   logic [31:0] ref_mem [int];

   logic        pend_en = 1'b0;
   logic        pend_we;
   logic [31:0] pend_addr, pend_wdata;
   logic [7:0]  pend_len;

   function automatic int idx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] len);
      @(negedge clk);
      chk("ready_idle", 66'(req_ready_o), 66'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_len = len;
      @(posedge clk);
   endtask

   // Called just after the accept edge; checks latency, every beat and the return to idle.
   task automatic follow(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [7:0] len, input int stall_pct, input int stall_beat,
                         input int stall_len, output int vcycles);
      int n, i, st, guard;
      logic [31:0] ea, ed;
      n = (we || len == 8'd0) ? 1 : int'(len);
      i = 0; st = 0; guard = 0; vcycles = 0;
      #1;
      chk("ready_low_after_accept", 66'(req_ready_o), 66'd0);
      if (we) ref_mem[idx(a)] = wd;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (pend_en) begin
               req_valid = 1'b1; req_we = pend_we; req_addr = pend_addr;
               req_wdata = pend_wdata; req_len = pend_len;
            end else begin
               req_valid = 1'b0;
            end
         end
         chk("wait_valid_low", 66'(r_valid), 66'd0);
         chk("wait_ready_low", 66'(req_ready_o), 66'd0);
      end
      while (i < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         ea = a + 32'(4 * i);
         ed = we ? wd : ref_mem[idx(ea)];
         chk("beat_valid", 66'(r_valid), 66'd1);
         chk("beat_addr", 66'(r_addr), 66'(ea));
         chk("beat_rdata", 66'(r_rdata), 66'(ed));
         chk("beat_hit", 66'(r_hit), 66'd1);
         chk("burst_ready_low", 66'(req_ready_o), 66'd0);
         vcycles++;
         if (i == stall_beat && st < stall_len) begin
            resp_ready = 1'b0;
            st++;
         end else begin
            resp_ready = ($urandom_range(99) >= 32'(stall_pct));
         end
         @(posedge clk);
         if (resp_ready) i++;
      end
      chk("beats_done", 66'(i), 66'(n));
      @(negedge clk);
      chk("end_resp_zero", resp_o, 66'd0);
      chk("end_ready_high", 66'(req_ready_o), 66'd1);
      resp_ready = 1'b1;
   endtask

   task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [7:0] len, input int stall_pct);
      int vc;
      start(we, a, wd, len);
      follow(we, a, wd, len, stall_pct, -1, 0, vc);
   endtask

   initial begin
      int vc;
      logic [31:0] a, d;
      int w;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_resp_zero", resp_o, 66'd0);
      chk("reset_ready", 66'(req_ready_o), 66'd1);
      rst = 1'b0;

      // Single write ack
      txn(1'b1, 32'h100, 32'hDEADBEEF, 8'd3, 0);

      // Preload 1..4 then burst read, no stalls
      for (int k = 0; k < 4; k++) txn(1'b1, 32'h200 + 32'(4 * k), 32'(k + 1), 8'd0, 0);
      start(1'b0, 32'h200, 32'h0, 8'd4);
      follow(1'b0, 32'h200, 32'h0, 8'd4, 0, -1, 0, vc);
      chk("burst4_valid_cycles", 66'(vc), 66'd4);

      // Same burst with a 3-cycle stall on beat 2
      start(1'b0, 32'h200, 32'h0, 8'd4);
      follow(1'b0, 32'h200, 32'h0, 8'd4, 0, 1, 3, vc);
      chk("stall_valid_cycles", 66'(vc), 66'd7);

      // len=0 read and index wrap at the top of the array
      txn(1'b1, 32'h40, 32'h1234_5678, 8'd0, 0);
      txn(1'b1, 32'h3FFFC, 32'hCAFE_0001, 8'd0, 0);
      txn(1'b1, 32'h0, 32'h0BAD_F00D, 8'd0, 0);
      start(1'b0, 32'h40, 32'h0, 8'd0);
      follow(1'b0, 32'h40, 32'h0, 8'd0, 0, -1, 0, vc);
      chk("len0_single_beat", 66'(vc), 66'd1);
      txn(1'b0, 32'h3FFFC, 32'h0, 8'd2, 0);

      // Request held during a burst is ignored until the burst ends
      pend_en = 1'b1; pend_we = 1'b1; pend_addr = 32'h300; pend_wdata = 32'hA5A5_5A5A; pend_len = 8'd0;
      start(1'b0, 32'h200, 32'h0, 8'd4);
      follow(1'b0, 32'h200, 32'h0, 8'd4, 30, -1, 0, vc);
      pend_en = 1'b0;
      @(posedge clk);
      follow(1'b1, 32'h300, 32'hA5A5_5A5A, 8'd0, 0, -1, 0, vc);
      txn(1'b0, 32'h300, 32'h0, 8'd1, 0);

      // Reset during WAIT
      start(1'b0, 32'h200, 32'h0, 8'd4);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_resp_zero", resp_o, 66'd0);
      chk("rst_wait_ready", 66'(req_ready_o), 66'd1);
      rst = 1'b0;

      // Reset mid-burst
      start(1'b0, 32'h200, 32'h0, 8'd4);
      @(negedge clk); req_valid = 1'b0; resp_ready = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      chk("pre_rst_in_burst", 66'(r_valid), 66'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_burst_resp_zero", resp_o, 66'd0);
      chk("rst_burst_ready", 66'(req_ready_o), 66'd1);
      rst = 1'b0;
      txn(1'b0, 32'h100, 32'h0, 8'd1, 0);

      // Random: fill word indices 0..271 (random upper/low address bits), then mix
      for (int k = 0; k < 272; k++) begin
         a = ($urandom() & 32'hFFFC_0000) | (32'(k) << 2) | 32'($urandom_range(3));
         txn(1'b1, a, $urandom(), 8'($urandom_range(255)), 0);
      end
      for (int k = 0; k < 60; k++) begin
         w = int'($urandom_range(255));
         a = ($urandom() & 32'hFFFC_0000) | (32'(w) << 2) | 32'($urandom_range(3));
         d = $urandom();
         if ($urandom_range(2) == 0) txn(1'b1, a, d, 8'($urandom_range(20)), 25);
         else                        txn(1'b0, a, d, 8'($urandom_range(16)), 25);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
